fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 5-stage RV32I pipeline: owns the PC register, drives the
//  combinational instruction memory address, and captures the returned word
//  into the IF/ID pipeline register.
//  Applies hazard-unit stall/flush and EX-stage branch/jump redirects.
// PARAMETERS
//  XLEN          32 (defs.vh)    datapath/PC width
//  RESET_VECTOR  32'h0000_0000   PC value loaded on reset
//  NOP_INSTR     32'h0000_0013   bubble encoding (addi x0,x0,0)
// PORTS
//  clk               in   1     rising-edge clock
//  rst_n             in   1     synchronous reset, active-low
//  stall_i           in   1     hold PC and IF/ID contents (load-use hazard)
//  flush_i           in   1     replace IF/ID contents with a bubble
//  redirect_valid_i  in   1     taken branch/jump from EX
//  redirect_pc_i     in   XLEN  redirect target
//  imem_addr_o       out  XLEN  byte address to instruction memory (= pc_q)
//  imem_instr_i      in   XLEN  instruction word, valid in the same cycle
//  if_id_valid_o     out  1     IF/ID holds a real instruction
//  if_id_pc_o        out  XLEN  PC of the IF/ID instruction
//  if_id_pc4_o       out  XLEN  if_id_pc_o + 4
//  if_id_instr_o     out  XLEN  instruction word in IF/ID
//  misalign_o        out  1     one-cycle pulse: redirect target had [1:0]!=0
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): pc_q=RESET_VECTOR; if_id_valid_o=0,
//    if_id_instr_o=NOP_INSTR, if_id_pc_o=0, if_id_pc4_o=0, misalign_o=0.
//  - imem_addr_o = pc_q combinationally; memory returns instr the same cycle.
//    Fetch-to-IF/ID latency: 1 clock. The first valid IF/ID entry appears on
//    the 1st posedge after rst_n rises, with pc = RESET_VECTOR.
//  - pc_next priority (highest first): reset > redirect > stall > pc_q+4.
//  - IF/ID priority: reset > (redirect | flush) -> bubble > stall -> hold >
//    load {valid=1, pc_q, pc_q+4, imem_instr_i}.
//  - Bubble: valid=0, instr=NOP_INSTR, pc/pc4 keep their previous values.
//  - Redirect with stall_i=1: redirect wins. PC loads the target and IF/ID
//    takes a bubble. The wrong-path fetch is never delivered.
//  - Flush with stall_i=1: IF/ID takes a bubble and the PC holds.
//  - Flush without redirect: PC advances normally (stall_i=0).
//  - Redirect target [1:0]!=0: PC loads {target[XLEN-1:2],2'b00}.
//    misalign_o=1 for exactly the next cycle; the EX/trap logic consumes it.
//  - Arithmetic is modulo 2^XLEN: pc_q=32'hFFFF_FFFC advances to 0 with no flag.
//  - pc_q[1:0] is always 2'b00.
//  - Reset asserted mid-stream: all state returns to reset values on that
//    edge, regardless of stall/flush/redirect.
//  - Registered outputs only change on posedge clk. No latches.
//  - No combinational path from stall/flush/redirect to imem_addr_o.
// TESTING
//  1 Reset, release, 4 free-run cycles, mem[i]=i+1 -> IF/ID pcs 0,4,8,12;
//    instr 1,2,3,4; valid=1 from the 1st edge.
//  2 stall_i=1 for 2 cycles at pc=8 -> imem_addr_o stays 8; IF/ID holds
//    pc=4/instr=2; resumes with pc=8.
//  3 redirect to 0x40 at pc=0x10 -> next edge: pc_q=0x40, IF/ID valid=0,
//    instr=0x13; next edge: IF/ID pc=0x40.
//  4 redirect 0x80 + stall_i=1 same cycle -> pc_q=0x80, bubble;
//    flush+stall -> bubble, PC held.
//  5 redirect 0x102 -> pc_q=0x100, misalign_o=1 for one cycle;
//    wrap: pc 0xFFFFFFFC -> 0.
//  6 rst_n=0 mid-run during a redirect -> pc_q=RESET_VECTOR, valid=0,
//    misalign_o=0 after that edge.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage: PC register, instruction memory address, IF/ID pipeline register.
// Handles hazard stall/flush and EX branch/jump redirects.
module fetch_stage #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter logic [XLEN-1:0] NOP_INSTR    = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [XLEN-1:0] imem_instr_i,
    output logic            if_id_valid_o,
    output logic [XLEN-1:0] if_id_pc_o,
    output logic [XLEN-1:0] if_id_pc4_o,
    output logic [XLEN-1:0] if_id_instr_o,
    output logic            misalign_o
);

    logic [XLEN-1:0] r_pc;
    logic            r_valid;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_pc4;
    logic [XLEN-1:0] r_ifid_instr;
    logic            r_misalign;

    logic [XLEN-1:0] w_pc4;
    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_reset_pc;
    logic            w_bubble;
    logic            w_misalign;

    assign w_pc4      = r_pc + XLEN'(4);
    assign w_redir_pc = {redirect_pc_i[XLEN-1:2], 2'b00};
    assign w_reset_pc = {RESET_VECTOR[XLEN-1:2], 2'b00};
    assign w_bubble   = redirect_valid_i | flush_i;
    assign w_misalign = redirect_valid_i & (|redirect_pc_i[1:0]);

    // Redirect outranks stall so the wrong-path fetch is never delivered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc         <= w_reset_pc;
            r_valid      <= 1'b0;
            r_ifid_pc    <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_instr <= NOP_INSTR;
            r_misalign   <= 1'b0;
        end else begin
            r_misalign <= w_misalign;

            if (redirect_valid_i) begin
                r_pc <= w_redir_pc;
            end else if (!stall_i) begin
                r_pc <= w_pc4;
            end

            if (w_bubble) begin
                r_valid      <= 1'b0;
                r_ifid_instr <= NOP_INSTR;
            end else if (!stall_i) begin
                r_valid      <= 1'b1;
                r_ifid_pc    <= r_pc;
                r_ifid_pc4   <= w_pc4;
                r_ifid_instr <= imem_instr_i;
            end
        end
    end

    assign imem_addr_o   = r_pc;
    assign if_id_valid_o = r_valid;
    assign if_id_pc_o    = r_ifid_pc;
    assign if_id_pc4_o   = r_ifid_pc4;
    assign if_id_instr_o = r_ifid_instr;
    assign misalign_o    = r_misalign;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: free-run, stall, redirect, flush,
// misaligned redirect, PC wrap and mid-stream reset.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        stall_i;
    logic        flush_i;
    logic        redirect_valid_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] imem_addr_o;
    logic [31:0] imem_instr_i;
    logic        if_id_valid_o;
    logic [31:0] if_id_pc_o;
    logic [31:0] if_id_pc4_o;
    logic [31:0] if_id_instr_o;
    logic        misalign_o;

    int total = 0;
    int bad   = 0;

    fetch_stage dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall_i         (stall_i),
        .flush_i         (flush_i),
        .redirect_valid_i(redirect_valid_i),
        .redirect_pc_i   (redirect_pc_i),
        .imem_addr_o     (imem_addr_o),
        .imem_instr_i    (imem_instr_i),
        .if_id_valid_o   (if_id_valid_o),
        .if_id_pc_o      (if_id_pc_o),
        .if_id_pc4_o     (if_id_pc4_o),
        .if_id_instr_o   (if_id_instr_o),
        .misalign_o      (misalign_o)
    );

    // Memory image: word i holds i+1.
    assign imem_instr_i = (imem_addr_o >> 2) + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        redirect_valid_i = 1'b0;
        redirect_pc_i = '0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (imem_addr_o !== 32'h0) begin
            bad++; $display("FAIL rst_pc got=%h exp=%h", imem_addr_o, 32'h0);
        end
        total++;
        if (if_id_valid_o !== 1'b0) begin
            bad++; $display("FAIL rst_valid got=%b exp=0", if_id_valid_o);
        end
        total++;
        if (if_id_instr_o !== 32'h13) begin
            bad++; $display("FAIL rst_instr got=%h exp=%h", if_id_instr_o, 32'h13);
        end
        total++;
        if (if_id_pc_o !== 32'h0 || if_id_pc4_o !== 32'h0) begin
            bad++; $display("FAIL rst_ifid_pc got=%h/%h exp=0/0", if_id_pc_o, if_id_pc4_o);
        end
        total++;
        if (misalign_o !== 1'b0) begin
            bad++; $display("FAIL rst_misalign got=%b exp=0", misalign_o);
        end
    endtask

    task automatic test_free_run();
        logic [31:0] exp_pc;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tick();
            exp_pc = 32'(i * 4);
            total++;
            if (if_id_valid_o !== 1'b1 || if_id_pc_o !== exp_pc
                || if_id_pc4_o !== exp_pc + 32'd4 || if_id_instr_o !== 32'(i + 1)) begin
                bad++;
                $display("FAIL run%0d got=%b/%h/%h/%h exp=1/%h/%h/%h", i, if_id_valid_o,
                         if_id_pc_o, if_id_pc4_o, if_id_instr_o,
                         exp_pc, exp_pc + 32'd4, 32'(i + 1));
            end
        end
        total++;
        if (imem_addr_o !== 32'h10) begin
            bad++; $display("FAIL run_addr got=%h exp=%h", imem_addr_o, 32'h10);
        end
    endtask

    task automatic test_stall();
        do_reset();
        tick();
        tick();
        stall_i = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if (imem_addr_o !== 32'h8 || if_id_pc_o !== 32'h4
                || if_id_instr_o !== 32'h2 || if_id_valid_o !== 1'b1) begin
                bad++;
                $display("FAIL stall%0d got=%h/%h/%h/%b exp=8/4/2/1", i, imem_addr_o,
                         if_id_pc_o, if_id_instr_o, if_id_valid_o);
            end
        end
        stall_i = 1'b0;
        tick();
        total++;
        if (if_id_pc_o !== 32'h8 || if_id_instr_o !== 32'h3 || imem_addr_o !== 32'hC) begin
            bad++;
            $display("FAIL stall_resume got=%h/%h/%h exp=8/3/c", if_id_pc_o,
                     if_id_instr_o, imem_addr_o);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 4; i++) tick();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h40;
        tick();
        redirect_valid_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'h40 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13
            || if_id_pc_o !== 32'hC || if_id_pc4_o !== 32'h10) begin
            bad++;
            $display("FAIL redir_bubble got=%h/%b/%h/%h/%h exp=40/0/13/c/10", imem_addr_o,
                     if_id_valid_o, if_id_instr_o, if_id_pc_o, if_id_pc4_o);
        end
        tick();
        total++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h40
            || if_id_pc4_o !== 32'h44 || if_id_instr_o !== 32'h11) begin
            bad++;
            $display("FAIL redir_target got=%b/%h/%h/%h exp=1/40/44/11", if_id_valid_o,
                     if_id_pc_o, if_id_pc4_o, if_id_instr_o);
        end
    endtask

    task automatic test_redirect_stall_flush();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h80;
        stall_i = 1'b1;
        tick();
        redirect_valid_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'h80 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13) begin
            bad++;
            $display("FAIL redir_stall got=%h/%b/%h exp=80/0/13", imem_addr_o,
                     if_id_valid_o, if_id_instr_o);
        end
        flush_i = 1'b1;
        tick();
        total++;
        if (imem_addr_o !== 32'h80 || if_id_valid_o !== 1'b0 || if_id_instr_o !== 32'h13) begin
            bad++;
            $display("FAIL flush_stall got=%h/%b/%h exp=80/0/13", imem_addr_o,
                     if_id_valid_o, if_id_instr_o);
        end
        stall_i = 1'b0;
        tick();
        flush_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'h84 || if_id_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL flush_adv got=%h/%b exp=84/0", imem_addr_o, if_id_valid_o);
        end
        tick();
        total++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h84 || if_id_instr_o !== 32'h22) begin
            bad++;
            $display("FAIL flush_resume got=%b/%h/%h exp=1/84/22", if_id_valid_o,
                     if_id_pc_o, if_id_instr_o);
        end
    endtask

    task automatic test_misalign_wrap();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h102;
        tick();
        redirect_valid_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'h100 || misalign_o !== 1'b1) begin
            bad++;
            $display("FAIL misalign got=%h/%b exp=100/1", imem_addr_o, misalign_o);
        end
        tick();
        total++;
        if (misalign_o !== 1'b0 || if_id_pc_o !== 32'h100 || if_id_instr_o !== 32'h41) begin
            bad++;
            $display("FAIL misalign_end got=%b/%h/%h exp=0/100/41", misalign_o,
                     if_id_pc_o, if_id_instr_o);
        end
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFC;
        tick();
        redirect_valid_i = 1'b0;
        total++;
        if (imem_addr_o !== 32'hFFFF_FFFC || misalign_o !== 1'b0) begin
            bad++;
            $display("FAIL wrap_load got=%h/%b exp=fffffffc/0", imem_addr_o, misalign_o);
        end
        tick();
        total++;
        if (imem_addr_o !== 32'h0 || if_id_pc_o !== 32'hFFFF_FFFC
            || if_id_pc4_o !== 32'h0 || if_id_instr_o !== 32'h4000_0000
            || misalign_o !== 1'b0) begin
            bad++;
            $display("FAIL wrap got=%h/%h/%h/%h/%b exp=0/fffffffc/0/40000000/0",
                     imem_addr_o, if_id_pc_o, if_id_pc4_o, if_id_instr_o, misalign_o);
        end
    endtask

    task automatic test_reset_mid();
        redirect_valid_i = 1'b1;
        redirect_pc_i = 32'h103;
        stall_i = 1'b1;
        flush_i = 1'b1;
        rst_n = 1'b0;
        tick();
        total++;
        if (imem_addr_o !== 32'h0 || if_id_valid_o !== 1'b0 || misalign_o !== 1'b0
            || if_id_instr_o !== 32'h13 || if_id_pc_o !== 32'h0) begin
            bad++;
            $display("FAIL rst_mid got=%h/%b/%b/%h/%h exp=0/0/0/13/0", imem_addr_o,
                     if_id_valid_o, misalign_o, if_id_instr_o, if_id_pc_o);
        end
        redirect_valid_i = 1'b0;
        stall_i = 1'b0;
        flush_i = 1'b0;
        rst_n = 1'b1;
        tick();
        total++;
        if (if_id_valid_o !== 1'b1 || if_id_pc_o !== 32'h0 || if_id_instr_o !== 32'h1) begin
            bad++;
            $display("FAIL rst_mid_resume got=%b/%h/%h exp=1/0/1", if_id_valid_o,
                     if_id_pc_o, if_id_instr_o);
        end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_stall();
        test_redirect();
        test_redirect_stall_flush();
        test_misalign_wrap();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
